// File: rtl/s1_sender_pkg.sv
// Framing constants and state encoding shared by the S1 sender and the S2 receiver.
package s1_sender_pkg;

  localparam int unsigned ADDR_W     = 3;
  localparam int unsigned DATA_W     = 18;
  localparam int unsigned WORDS      = 8;
  localparam int unsigned PKT_LEN    = ADDR_W + DATA_W;
  localparam int unsigned GAP_CYCLES = 1;
  localparam int unsigned CNT_W      = 5;
  localparam int unsigned K_W        = ADDR_W + 1;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_SEND  = 3'd2,
    ST_DONE  = 3'd3,
    ST_HALT  = 3'd4
  } state_e;

  // Packet layout: address field in the MSBs, data below it.
  function automatic logic [PKT_LEN-1:0] make_pkt(input logic [ADDR_W-1:0] addr,
                                                  input logic [DATA_W-1:0] data);
    return {addr, data};
  endfunction

endpackage

// File: rtl/s1_piso.sv
// Parallel-load, shift-left register presenting its MSB as the serial bit.
module s1_piso
  import s1_sender_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               i_load,
  input  logic               i_shift,
  input  logic [PKT_LEN-1:0] i_d,
  output logic               o_msb
);

  logic [PKT_LEN-1:0] r_sh;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sh <= '0;
    end else if (i_load) begin
      r_sh <= i_d;
    end else if (i_shift) begin
      r_sh <= {r_sh[PKT_LEN-2:0], 1'b0};
    end
  end

  assign o_msb = r_sh[PKT_LEN-1];

endmodule

// File: rtl/s1_sender.sv
// Reads all RB1 words once after reset and streams each as an addressed serial packet on sen/sd.
module s1_sender
  import s1_sender_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  output logic              RB1_RW,
  output logic [ADDR_W-1:0] RB1_A,
  input  logic [DATA_W-1:0] RB1_Q,
  output logic              sen,
  output logic              sd,
  output logic              S1_done
);

  state_e             r_state;
  state_e             w_state_nxt;
  logic [K_W-1:0]     r_k;
  logic [CNT_W-1:0]   r_cnt;
  logic               w_load;
  logic               w_shift;
  logic               w_last_bit;
  logic               w_msb;

  assign w_last_bit = (r_cnt == CNT_W'(PKT_LEN - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // FETCH reloads the bit counter; SEND advances it and bumps k on the last bit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_k   <= '0;
      r_cnt <= '0;
    end else if (w_load) begin
      r_cnt <= '0;
    end else if (w_shift) begin
      r_cnt <= r_cnt + CNT_W'(1);
      if (w_last_bit) begin
        r_k <= r_k + K_W'(1);
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_shift     = 1'b0;
    sen         = 1'b1;
    sd          = 1'b0;
    S1_done     = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        w_state_nxt = ST_FETCH;
      end
      ST_FETCH: begin
        w_load      = 1'b1;
        w_state_nxt = ST_SEND;
      end
      ST_SEND: begin
        w_shift = 1'b1;
        sen     = 1'b0;
        sd      = w_msb;
        if (w_last_bit) begin
          w_state_nxt = (r_k == K_W'(WORDS - 1)) ? ST_DONE : ST_FETCH;
        end
      end
      ST_DONE: begin
        S1_done     = 1'b1;
        w_state_nxt = ST_HALT;
      end
      ST_HALT: begin
        w_state_nxt = ST_HALT;
      end
      default: begin
        w_state_nxt = ST_HALT;
      end
    endcase
  end

  assign RB1_RW = 1'b1;
  assign RB1_A  = r_k[ADDR_W-1:0];

  s1_piso u_piso (
    .clk     (clk),
    .rst     (rst),
    .i_load  (w_load),
    .i_shift (w_shift),
    .i_d     (make_pkt(r_k[ADDR_W-1:0], RB1_Q)),
    .o_msb   (w_msb)
  );

endmodule

// File: tb/tb_s1_sender.sv
// Scoreboard bench for s1_sender: an RB1 model feeds the DUT, a receiver model decodes sen/sd.
module tb_s1_sender;

  logic        clk;
  logic        rst;
  logic        RB1_RW;
  logic [2:0]  RB1_A;
  logic [17:0] RB1_Q;
  logic        sen;
  logic        sd;
  logic        S1_done;

  logic [17:0] rb1_mem [8];
  logic [17:0] rb2_mem [8];
  logic [20:0] sb [$];
  int          errors;
  int          checks;

  assign RB1_Q = rb1_mem[RB1_A];

  s1_sender dut (
    .clk     (clk),
    .rst     (rst),
    .RB1_RW  (RB1_RW),
    .RB1_A   (RB1_A),
    .RB1_Q   (RB1_Q),
    .sen     (sen),
    .sd      (sd),
    .S1_done (S1_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // kind: 0 = i*0x4D2, 1 = all ones, 2 = all zeros, 3 = random
  task automatic load_rb1(input int kind);
    logic [20:0] p;
    sb.delete();
    for (int i = 0; i < 8; i++) begin
      case (kind)
        0:       rb1_mem[i] = 18'(i * 18'h004D2);
        1:       rb1_mem[i] = 18'h3FFFF;
        2:       rb1_mem[i] = 18'h00000;
        default: rb1_mem[i] = 18'($urandom);
      endcase
      rb2_mem[i] = 18'h2AAAA;
      p = {3'(i), rb1_mem[i]};
      sb.push_back(p);
    end
  endtask

  // Called right after rst is released on a falling edge; samples each cycle on the falling edge.
  task automatic run_seq(input string tag, input int abort_cyc);
    int          cyc;
    int          nb;
    int          done_cnt;
    logic [20:0] acc;
    logic [20:0] exp_pkt;
    logic        exp_sen;
    logic        exp_done;
    cyc      = 1;
    nb       = 0;
    done_cnt = 0;
    acc      = '0;
    for (int n = 0; n < 184; n++) begin
      @(negedge clk);
      cyc++;
      exp_sen  = !(cyc >= 3 && cyc <= 177 && ((cyc - 3) % 22) <= 20);
      exp_done = (cyc == 178);
      checks++;
      if (sen !== exp_sen) begin
        errors++;
        $display("FAIL %s sen cyc=%0d got=%b exp=%b", tag, cyc, sen, exp_sen);
      end
      checks++;
      if (S1_done !== exp_done) begin
        errors++;
        $display("FAIL %s S1_done cyc=%0d got=%b exp=%b", tag, cyc, S1_done, exp_done);
      end
      if (S1_done === 1'b1) done_cnt++;
      checks++;
      if (RB1_RW !== 1'b1) begin
        errors++;
        $display("FAIL %s RB1_RW cyc=%0d got=%b exp=1", tag, cyc, RB1_RW);
      end
      if (sen === 1'b1) begin
        checks++;
        if (sd !== 1'b0) begin
          errors++;
          $display("FAIL %s sd_idle cyc=%0d got=%b exp=0", tag, cyc, sd);
        end
      end
      if (cyc == 3 || cyc == 113 || cyc == 114 || cyc == 115) begin
        checks++;
        if (sd !== ((cyc == 114) ? 1'b0 : (cyc != 3))) begin
          errors++;
          $display("FAIL %s first_bits cyc=%0d got=%b", tag, cyc, sd);
        end
      end
      if (sen === 1'b0) begin
        acc = {acc[19:0], sd};
        nb++;
      end else if (nb > 0) begin
        checks++;
        if (nb != 21) begin
          errors++;
          $display("FAIL %s pkt_len cyc=%0d got=%0d exp=21", tag, cyc, nb);
        end
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL %s extra_pkt cyc=%0d got=%h exp=none", tag, cyc, acc);
        end else begin
          exp_pkt = sb.pop_front();
          if (acc !== exp_pkt) begin
            errors++;
            $display("FAIL %s pkt cyc=%0d got=%h exp=%h", tag, cyc, acc, exp_pkt);
          end
        end
        rb2_mem[acc[20:18]] = acc[17:0];
        nb = 0;
      end
      if (cyc == abort_cyc) return;
    end
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL %s missing_pkts got=%0d left exp=0", tag, sb.size());
    end
    checks++;
    if (done_cnt != 1) begin
      errors++;
      $display("FAIL %s done_pulses got=%0d exp=1", tag, done_cnt);
    end
  endtask

  task automatic start(input int kind);
    rst = 1'b1;
    load_rb1(kind);
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    load_rb1(0);
    repeat (3) @(negedge clk);
    checks++;
    if ({sen, sd, RB1_RW, RB1_A, S1_done} !== 7'b1_0_1_000_0) begin
      errors++;
      $display("FAIL reset outs got=%b exp=1010000", {sen, sd, RB1_RW, RB1_A, S1_done});
    end
  endtask

  task automatic test_sequence();
    start(0);
    run_seq("seq", 0);
  endtask

  task automatic test_ones_zeros();
    start(1);
    run_seq("ones", 0);
    start(2);
    run_seq("zeros", 0);
  endtask

  task automatic test_back_to_back();
    start(3);
    run_seq("b2b", 0);
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (rb2_mem[i] !== rb1_mem[i]) begin
        errors++;
        $display("FAIL b2b rb2[%0d] got=%h exp=%h", i, rb2_mem[i], rb1_mem[i]);
      end
    end
  endtask

  task automatic test_mid_reset();
    start(0);
    run_seq("pre_rst", 79);
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if ({sen, sd, RB1_A, S1_done} !== 6'b1_0_000_0) begin
      errors++;
      $display("FAIL mid_reset outs got=%b exp=100000", {sen, sd, RB1_A, S1_done});
    end
    load_rb1(0);
    @(negedge clk);
    rst = 1'b0;
    run_seq("restart", 0);
  endtask

  task automatic test_hold();
    int bad;
    bad = 0;
    for (int n = 0; n < 300; n++) begin
      @(negedge clk);
      if (sen !== 1'b1 || sd !== 1'b0 || S1_done !== 1'b0 || RB1_RW !== 1'b1) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL hold bad_cycles got=%0d exp=0", bad);
    end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    rst    = 1'b1;
    for (int i = 0; i < 8; i++) rb1_mem[i] = '0;
    test_reset();
    test_sequence();
    test_hold();
    test_ones_zeros();
    test_back_to_back();
    test_mid_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
